// File: rtl/mdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mdu_pkg                                                  |
// | Purpose : Shared types for the multiply/divide sequencer: operation |
// |           codes, FSM states and HI/LO read-select codes.           |
// | Ports   : none (package)                                           |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package mdu_pkg;

   // Operation encoding as decoded into mdopE
   typedef enum logic [1:0] {
      MDOP_MULT  = 2'b00,
      MDOP_MULTU = 2'b01,
      MDOP_DIV   = 2'b10,
      MDOP_DIVU  = 2'b11
   } mdop_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   // hiloE read-select codes; 2'b11 is reserved and reads as none
   localparam logic [1:0] HILO_NONE = 2'b00;
   localparam logic [1:0] HILO_LO   = 2'b01;
   localparam logic [1:0] HILO_HI   = 2'b10;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mdu_sequencer_if                                         |
// | Purpose : Execute-stage bundle between the core and the mul/div    |
// |           sequencer.                                               |
// | Ports   : multdivE/mdopE/flushE/srcaE/srcbE - operation issue      |
// |           hiloE/hiloresultE                 - MFHI/MFLO read       |
// |           mdstallE/busy                     - hazard signalling    |
// |           hi/lo                             - architectural HI/LO  |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
interface mdu_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             multdivE;
   logic [1:0]       mdopE;
   logic [1:0]       hiloE;
   logic             flushE;
   logic [WIDTH-1:0] srcaE;
   logic [WIDTH-1:0] srcbE;
   logic [WIDTH-1:0] hiloresultE;
   logic             mdstallE;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   // Core / Execute-stage side
   modport master (
      output multdivE, mdopE, hiloE, flushE, srcaE, srcbE,
      input  hiloresultE, mdstallE, busy, hi, lo
   );

   // Sequencer side
   modport slave (
      input  multdivE, mdopE, hiloE, flushE, srcaE, srcbE,
      output hiloresultE, mdstallE, busy, hi, lo
   );
endinterface : mdu_sequencer_if
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mdu_step                                                 |
// | Purpose : One radix-2 iteration of the multiply/divide datapath.   |
// |           Multiply: shift-add, multiplier consumed from acc_lo[0], |
// |           product shifts right into {acc_hi, acc_lo}.              |
// |           Divide: restoring subtract-shift, dividend shifts out of |
// |           acc_lo MSB into the remainder (acc_hi), quotient bits    |
// |           shift into acc_lo LSB.                                   |
// | Ports   : is_div          in  select divide iteration              |
// |           acc_hi/acc_lo   in  current accumulator pair             |
// |           opnd            in  multiplicand or divisor magnitude    |
// |           nxt_hi/nxt_lo   out accumulator pair after this step     |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module mdu_step #(
   parameter int WIDTH = 32
) (
   input  wire logic             is_div,
   input  wire logic [WIDTH-1:0] acc_hi,
   input  wire logic [WIDTH-1:0] acc_lo,
   input  wire logic [WIDTH-1:0] opnd,
   output logic      [WIDTH-1:0] nxt_hi,
   output logic      [WIDTH-1:0] nxt_lo
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_shifted;
   logic [WIDTH:0] w_diff;

   always_comb begin
      // Multiply: the carry out of the add becomes the new product MSB.
      w_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      // Divide: partial remainder doubled with the next dividend bit.
      w_shifted = {acc_hi, acc_lo[WIDTH-1]};
      w_diff    = w_shifted - {1'b0, opnd};

      nxt_hi = w_sum[WIDTH:1];
      nxt_lo = {w_sum[0], acc_lo[WIDTH-1:1]};

      if (is_div) begin
         // Remainder stays below the divisor, so the borrow bit of the
         // WIDTH+1 subtraction alone decides whether the divisor fits.
         if (!w_diff[WIDTH]) begin
            nxt_hi = w_diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = w_shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule : mdu_step
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mdu_sequencer                                            |
// | Purpose : Multi-cycle MULT/MULTU/DIV/DIVU unit for Execute. Runs   |
// |           WIDTH radix-2 iterations on operand magnitudes, applies  |
// |           signs in a final FIX cycle and writes HI/LO. Serves       |
// |           MFHI/MFLO and requests a stall while an op is in flight. |
// | Ports   : clk    in  clock, rising edge                            |
// |           reset  in  asynchronous active-low reset                 |
// |           bus    slave modport of mdu_sequencer_if                 |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  wire logic         clk,
   input  wire logic         reset,
   mdu_sequencer_if.slave    bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   state_e           state_q,    state_d;
   mdop_e            op_q,       op_d;
   logic             sign_a_q,   sign_a_d;
   logic             sign_b_q,   sign_b_d;
   logic             divzero_q,  divzero_d;
   logic [CW-1:0]    cnt_q,      cnt_d;
   logic [WIDTH-1:0] opnd_q,     opnd_d;
   logic [WIDTH-1:0] acc_hi_q,   acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q,   acc_lo_d;
   logic [WIDTH-1:0] srca_q,     srca_d;
   logic [WIDTH-1:0] hi_q,       hi_d;
   logic [WIDTH-1:0] lo_q,       lo_d;

   mdop_e            w_mdop;
   logic             w_in_div;
   logic             w_in_signed;
   logic             w_in_sa;
   logic             w_in_sb;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic             w_busy;
   logic             w_stall;
   logic             w_accept;
   logic             w_run_div;
   logic [WIDTH-1:0] w_step_hi;
   logic [WIDTH-1:0] w_step_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0] w_quot_fix;
   logic [WIDTH-1:0] w_rem_fix;

   // ------------------------------------------------------------------
   // Single shared iteration datapath
   // ------------------------------------------------------------------
   assign w_run_div = (op_q == MDOP_DIV) || (op_q == MDOP_DIVU);

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .is_div (w_run_div),
      .acc_hi (acc_hi_q),
      .acc_lo (acc_lo_q),
      .opnd   (opnd_q),
      .nxt_hi (w_step_hi),
      .nxt_lo (w_step_lo)
   );

   // ------------------------------------------------------------------
   // Handshake outputs
   // ------------------------------------------------------------------
   assign w_busy  = (state_q != ST_IDLE);
   assign w_stall = w_busy & (bus.multdivE | (bus.hiloE == HILO_LO) |
                              (bus.hiloE == HILO_HI));

   assign bus.busy     = w_busy;
   assign bus.mdstallE = w_stall;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

   always_comb begin
      case (bus.hiloE)
         HILO_LO: bus.hiloresultE = lo_q;
         HILO_HI: bus.hiloresultE = hi_q;
         default: bus.hiloresultE = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Issue-side operand conditioning
   // ------------------------------------------------------------------
   always_comb begin
      w_mdop      = mdop_e'(bus.mdopE);
      w_in_div    = (w_mdop == MDOP_DIV) || (w_mdop == MDOP_DIVU);
      w_in_signed = (w_mdop == MDOP_MULT) || (w_mdop == MDOP_DIV);
      w_in_sa     = w_in_signed & bus.srcaE[WIDTH-1];
      w_in_sb     = w_in_signed & bus.srcbE[WIDTH-1];
      // The most-negative value maps onto itself, which read as unsigned
      // is the correct magnitude; DIV min/-1 then needs no special case.
      w_abs_a     = w_in_sa ? (~bus.srcaE + 1'b1) : bus.srcaE;
      w_abs_b     = w_in_sb ? (~bus.srcbE + 1'b1) : bus.srcbE;
      w_accept    = bus.multdivE & ~bus.flushE & ~w_stall;
   end

   // ------------------------------------------------------------------
   // Sign fix-up of the finished magnitude result
   // ------------------------------------------------------------------
   always_comb begin
      w_prod     = {acc_hi_q, acc_lo_q};
      w_prod_fix = (sign_a_q ^ sign_b_q) ? (~w_prod + 1'b1) : w_prod;
      w_quot_fix = (sign_a_q ^ sign_b_q) ? (~acc_lo_q + 1'b1) : acc_lo_q;
      w_rem_fix  = sign_a_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
   end

   // ------------------------------------------------------------------
   // FSM next-state and datapath control
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      divzero_d = divzero_q;
      cnt_d     = cnt_q;
      opnd_d    = opnd_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      srca_d    = srca_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               state_d   = ST_RUN;
               op_d      = w_mdop;
               sign_a_d  = w_in_sa;
               sign_b_d  = w_in_sb;
               divzero_d = w_in_div && (bus.srcbE == '0);
               cnt_d     = '0;
               srca_d    = bus.srcaE;
               acc_hi_d  = '0;
               // Multiply iterates over the multiplier bits in acc_lo;
               // divide shifts the dividend out of acc_lo.
               acc_lo_d  = w_in_div ? w_abs_a : w_abs_b;
               opnd_d    = w_in_div ? w_abs_b : w_abs_a;
            end
         end

         ST_RUN: begin
            acc_hi_d = w_step_hi;
            acc_lo_d = w_step_lo;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == C_LAST) begin
               state_d = ST_FIX;
            end
         end

         ST_FIX: begin
            state_d = ST_IDLE;
            if (w_run_div) begin
               if (divzero_q) begin
                  lo_d = '1;
                  hi_d = srca_q;
               end else begin
                  lo_d = w_quot_fix;
                  hi_d = w_rem_fix;
               end
            end else begin
               lo_d = w_prod_fix[WIDTH-1:0];
               hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         op_q      <= MDOP_MULT;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         divzero_q <= 1'b0;
         cnt_q     <= '0;
         opnd_q    <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         srca_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         sign_a_q  <= sign_a_d;
         sign_b_q  <= sign_b_d;
         divzero_q <= divzero_d;
         cnt_q     <= cnt_d;
         opnd_q    <= opnd_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         srca_q    <= srca_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

endmodule : mdu_sequencer
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_mdu_sequencer                                         |
// | Purpose : Self-checking bench for mdu_sequencer: directed cases    |
// |           plus random operations compared with an arithmetic       |
// |           reference model.                                         |
// | Ports   : none                                                     |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_mdu_sequencer;

   localparam int WIDTH   = 32;
   localparam int C_LAT   = WIDTH + 1;
   localparam int C_BOUND = 100;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   logic [31:0] model_hi;
   logic [31:0] model_lo;

   mdu_sequencer_if #(.WIDTH(WIDTH)) bus ();

   mdu_sequencer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference results straight from integer arithmetic in 64 bits.
   function automatic void ref_model(input logic [1:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] rh,
                                     output logic [31:0] rl);
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      rh = '0;
      rl = '0;
      case (op)
         2'b00: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
         2'b10: begin
            if (b == 32'd0) begin rl = 32'hFFFF_FFFF; rh = a; end
            else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
         end
         default: begin
            if (b == 32'd0) begin rl = 32'hFFFF_FFFF; rh = a; end
            else begin rl = a / b; rh = a % b; end
         end
      endcase
   endfunction

   // Ticks until busy drops; returns the number of edges spent busy.
   task automatic wait_done(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < C_BOUND) begin
         tick();
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
      int n;
      bus.multdivE = 1'b1;
      bus.mdopE    = op;
      bus.srcaE    = a;
      bus.srcbE    = b;
      tick();
      bus.multdivE = 1'b0;
      // Operands must only matter at the accept edge.
      bus.srcaE    = $urandom;
      bus.srcbE    = $urandom;
      check({tag, ".busy"}, 32'(bus.busy), 32'd1);
      wait_done(n);
      check({tag, ".lat"}, 32'(n), 32'(C_LAT));
      ref_model(op, a, b, model_hi, model_lo);
      check({tag, ".hi"}, bus.hi, model_hi);
      check({tag, ".lo"}, bus.lo, model_lo);
   endtask

   initial begin
      int n;
      logic [1:0] op;
      logic [31:0] a;
      logic [31:0] b;
      errors       = 0;
      checks       = 0;
      model_hi     = '0;
      model_lo     = '0;
      reset        = 1'b0;
      bus.multdivE = 1'b0;
      bus.mdopE    = 2'b00;
      bus.hiloE    = 2'b00;
      bus.flushE   = 1'b0;
      bus.srcaE    = '0;
      bus.srcbE    = '0;

      // Reset state
      tick();
      tick();
      check("rst.busy", 32'(bus.busy), 32'd0);
      check("rst.stall", 32'(bus.mdstallE), 32'd0);
      check("rst.hi", bus.hi, 32'd0);
      check("rst.lo", bus.lo, 32'd0);
      reset = 1'b1;
      tick();

      // Directed arithmetic cases
      run_op("mult7x-3", 2'b00, 32'd7, 32'hFFFF_FFFD);
      check("mult7x-3.hi_const", bus.hi, 32'hFFFF_FFFF);
      check("mult7x-3.lo_const", bus.lo, 32'hFFFF_FFEB);

      // MULTU then DIV held stalled and accepted in the release cycle
      bus.multdivE = 1'b1;
      bus.mdopE    = 2'b01;
      bus.srcaE    = 32'hFFFF_FFFF;
      bus.srcbE    = 32'hFFFF_FFFF;
      tick();
      bus.mdopE    = 2'b10;
      bus.srcaE    = 32'hFFFF_FFF9;
      bus.srcbE    = 32'd2;
      #1;
      check("b2b.stall", 32'(bus.mdstallE), 32'd1);
      wait_done(n);
      check("multu.lat", 32'(n), 32'(C_LAT));
      check("multu.hi", bus.hi, 32'hFFFF_FFFE);
      check("multu.lo", bus.lo, 32'h0000_0001);
      check("b2b.release_stall", 32'(bus.mdstallE), 32'd0);
      tick();
      bus.multdivE = 1'b0;
      check("b2b.accepted", 32'(bus.busy), 32'd1);
      wait_done(n);
      check("div-7/2.lat", 32'(n), 32'(C_LAT));
      check("div-7/2.lo", bus.lo, 32'hFFFF_FFFD);
      check("div-7/2.hi", bus.hi, 32'hFFFF_FFFF);

      run_op("divu100/0", 2'b11, 32'd100, 32'd0);
      run_op("div0/0", 2'b10, 32'h8000_0005, 32'd0);
      run_op("divmin/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      check("divmin/-1.lo_const", bus.lo, 32'h8000_0000);
      check("divmin/-1.hi_const", bus.hi, 32'd0);

      // MFLO arriving mid-operation stalls until the result lands
      bus.multdivE = 1'b1;
      bus.mdopE    = 2'b00;
      bus.srcaE    = 32'd6;
      bus.srcbE    = 32'd7;
      tick();
      bus.multdivE = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      bus.hiloE = 2'b01;
      #1;
      check("mflo.stall", 32'(bus.mdstallE), 32'd1);
      wait_done(n);
      check("mflo.wait", 32'(n), 32'(C_LAT - 4));
      check("mflo.nostall", 32'(bus.mdstallE), 32'd0);
      check("mflo.value", bus.hiloresultE, 32'd42);
      model_hi = 32'd0;
      model_lo = 32'd42;

      // MFHI with nothing in flight, and the reserved code
      bus.hiloE = 2'b10;
      #1;
      check("mfhi.stall", 32'(bus.mdstallE), 32'd0);
      check("mfhi.value", bus.hiloresultE, model_hi);
      bus.hiloE = 2'b11;
      #1;
      check("hilo11.value", bus.hiloresultE, 32'd0);
      bus.hiloE = 2'b00;

      // Flushed issue in IDLE is ignored
      bus.multdivE = 1'b1;
      bus.flushE   = 1'b1;
      bus.srcaE    = 32'd9;
      bus.srcbE    = 32'd9;
      tick();
      bus.multdivE = 1'b0;
      bus.flushE   = 1'b0;
      check("flush.busy", 32'(bus.busy), 32'd0);
      check("flush.hi", bus.hi, model_hi);
      check("flush.lo", bus.lo, model_lo);

      // Random operations
      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 20)) - 32'd10;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20)) - 32'd10;
         run_op($sformatf("rand%0d", i), op, a, b);
      end

      // Asynchronous reset during RUN
      bus.multdivE = 1'b1;
      bus.mdopE    = 2'b00;
      bus.srcaE    = 32'd12345;
      bus.srcbE    = 32'd678;
      tick();
      bus.multdivE = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      #2;
      reset = 1'b0;
      #1;
      check("arst.busy", 32'(bus.busy), 32'd0);
      check("arst.hi", bus.hi, 32'd0);
      check("arst.lo", bus.lo, 32'd0);
      #1;
      reset = 1'b1;
      tick();
      run_op("mult2x3", 2'b00, 32'd2, 32'd3);
      check("mult2x3.lo_const", bus.lo, 32'd6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mdu_sequencer
`default_nettype wire

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide unit for the pipelined core: it accepts a MULT/MULTU/DIV/DIVU issued from the Execute stage, runs an iterative radix-2 shift-add/restoring-divide datapath for WIDTH cycles, and writes the HI/LO register pair. It also serves MFHI/MFLO reads. It raises a stall to the hazard unit whenever a new multiply/divide or a HI/LO read reaches Execute while an operation is still in flight. It sits beside the ALU in Execute and is controlled by the decoded multdiv/hilo fields.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; asserted (0) forces the reset state immediately
- multdivE  in  1  multiply/divide instruction valid in Execute
- mdopE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- hiloE  in  2  00 none, 01 MFLO, 10 MFHI, 11 reserved (treated as none)
- flushE  in  1  Execute flush; suppresses acceptance of multdivE in the same cycle
- srcaE  in  WIDTH  rs operand (multiplicand/dividend)
- srcbE  in  WIDTH  rt operand (multiplier/divisor)
- hiloresultE  out  WIDTH  LO when hiloE=01, HI when hiloE=10, else 0
- mdstallE  out  1  stall request to hazard unit
- busy  out  1  operation in flight
- hi, lo  out  WIDTH  architectural HI/LO

## Operation
- Reset: state IDLE, hi=lo=0, busy=0, mdstallE=0, internal accumulators=0.
- States: IDLE, RUN, FIX.
- IDLE→RUN: on an edge where multdivE=1, flushE=0, and mdstallE=0. Latch op, sign flags (signed ops only) and |srcaE|, |srcbE|; clear iteration counter.
- RUN: one radix-2 step per cycle. MULT uses a shift-add into a 2·WIDTH product. DIV uses a restoring subtract-shift. Counter counts 0..WIDTH-1. After step WIDTH-1 → FIX.
- FIX: apply signs and write hi/lo on the edge leaving FIX; then → IDLE.
- Sign rules, MULT: negate the 2·WIDTH product if signa≠signb.
- Sign rules, DIV: quotient sign = signa^signb; remainder sign = signa. LO=quotient, HI=remainder.
- Divide by zero, both DIV and DIVU: LO=all ones, HI=dividend (original srcaE). No trap.
- DIV of most-negative by −1: LO=0x8000_0000, HI=0 (falls out of the magnitude method; required).
- Multi-cycle stall: mdstallE = busy & (multdivE | hiloE∈{01,10}), combinational.
- A stalled instruction is held in Execute by the hazard unit and is accepted, or read, the cycle busy drops.
- hiloresultE is combinational from hi/lo and is only meaningful when mdstallE=0.
- flushE does not abort an operation already in RUN/FIX; that operation has committed.
- reset mid-operation: return to IDLE at once; hi/lo=0; the result is lost.

## Timing
- Start accepted at edge t0. busy=1 from after t0 until edge t0+WIDTH+1, i.e. WIDTH+1 cycles (WIDTH RUN + 1 FIX).
- hi/lo take new values at edge t0+WIDTH+1; busy=0 in the same cycle.
- A multdivE arriving in that cycle is accepted back-to-back (no idle bubble).
- MFHI/MFLO issued in the cycle busy falls reads the new value with no stall.
- A read with no op in flight has zero-cycle latency.
- srcaE/srcbE are sampled only at the accept edge.

## Structure
- Package mdu_pkg holds:
  - typedef enum for mdop (MULT, MULTU, DIV, DIVU)
  - typedef enum for state (IDLE, RUN, FIX)
  - localparams HILO_NONE/HILO_LO/HILO_HI
- Sub-module mdu_step: combinational single-iteration datapath (shift-add or subtract-shift select), instantiated once.
- mdu_sequencer owns the FSM, counter, sign fix-up and HI/LO registers.

## Test plan
- MULT 7 × −3 (0x00000007, 0xFFFFFFFD) → at t0+33: hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then DIV −7/2 issued back-to-back in the release cycle → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 → lo=0xFFFFFFFF, hi=100. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- MFLO presented 5 cycles after a MULT 6×7 start → mdstallE=1 until busy falls, then hiloresultE=42 with mdstallE=0. MFHI with no op in flight → no stall.
- multdivE with flushE=1 in IDLE → no start; busy stays 0, hi/lo unchanged.
- reset driven low at RUN iteration 10 → asynchronously IDLE, busy=0, hi=lo=0. A subsequent MULT 2×3 → lo=6 after 33 cycles.
